// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder for WIDTH-bit operands with carry-in.
//
// One full-adder cell and a carry flop produce one sum bit per clock, LSB first.
// A start/busy/done handshake frames each operation:
//   - start is accepted in IDLE or DONE.
//   - busy is high for WIDTH cycles.
//   - done pulses for one cycle when sum/cout/overflow update.
// Results hold until the next done, so they stay stable while an operation runs.
//
// Optional feature (compile-time macro):
//   SERIAL_ADDER_SUB_EN - when defined, sub=1 at start latches ~b and ~cin,
//                         so the result is a - b - cin. When undefined, the
//                         sub input is not used and the block always adds.
//
// Parameters:
//   WIDTH     operand/result width, legal range 2..32
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     operation request, sampled while busy=0
//   a, b      operands, sampled with start
//   cin       carry-in, sampled with start
//   sub       subtract select, sampled with start (see SERIAL_ADDER_SUB_EN)
//   sum       result register
//   cout      carry out of the MSB (in subtract mode, 1 means no borrow)
//   overflow  signed overflow: carry into MSB XOR carry out of MSB
//   busy      operation in progress (registered, high exactly in RUN)
//   done      one-cycle pulse, results valid
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc_q;
    logic             carry_q;
    logic [CntW-1:0]  cnt_q;

    // Operand conditioning at latch time.
    logic [WIDTH-1:0] b_load;
    logic             c_load;

`ifdef SERIAL_ADDER_SUB_EN
    // Two's-complement subtract: a + ~b + ~cin = a - b - cin.
    assign b_load = sub ? ~b : b;
    assign c_load = sub ? ~cin : cin;
`else
    assign b_load = b;
    assign c_load = cin;
    logic unused_sub;
    assign unused_sub = sub;
`endif

    // The single full-adder cell.
    logic bit_s;
    logic bit_c;
    assign bit_s = a_q[0] ^ b_q[0] ^ carry_q;
    assign bit_c = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

    logic last_bit;
    assign last_bit = (cnt_q == LastBit);

    // The accumulator shifts right every bit, so after the last shift its LSB
    // position never holds a result bit; the final sum is formed from the
    // incoming bit plus the upper WIDTH-1 accumulator bits.
    logic [WIDTH-1:0] acc_next;
    assign acc_next = {bit_s, acc_q[WIDTH-1:1]};

    logic unused_acc_lsb;
    assign unused_acc_lsb = acc_q[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state_q)
                StRun: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    carry_q <= bit_c;
                    acc_q   <= acc_next;
                    cnt_q   <= cnt_q + 1'b1;
                    if (last_bit) begin
                        // carry_q here is the carry into the MSB.
                        sum      <= acc_next;
                        cout     <= bit_c;
                        overflow <= carry_q ^ bit_c;
                        state_q  <= StDone;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new operation; DONE with
                    // start goes straight back to RUN for back-to-back use.
                    done <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b_load;
                        carry_q <= c_load;
                        cnt_q   <= '0;
                        state_q <= StRun;
                        busy    <= 1'b1;
                    end else begin
                        state_q <= StIdle;
                    end
                end
            endcase
        end
    end

endmodule
